// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/load-store memory arbiter
package mem_arb_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int MEM_DEPTH = 128;
  localparam logic [2:0] MEM_STAGE = 3'd3;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, ERR} state_e;
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(MEM_DEPTH);
  endfunction
endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: 2-way round-robin picker; last grant advances only on a real grant
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant
);
  logic last_grant_q, last_grant_d;
  always_comb begin
    grant = req == 2'b01 ? PORT_IF : req == 2'b10 ? PORT_DM : ~last_grant_q;
    last_grant_d = advance ? grant : last_grant_q;
  end
  // Reset to the data port so fetch wins the first tie
  always_ff @(posedge clock) begin
    if (reset) last_grant_q <= PORT_DM;
    else last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the stage-gated main memory between fetch and load/store ports
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_invalue,
  output logic [2:0]        mem_stage,
  input  logic [DATA_W-1:0] mem_outvalue
);
  state_e state_q, state_d;
  logic port_q, port_d, we_q, we_d, grant, advance;
  logic [ADDR_W-1:0] addr_q, addr_d, req_addr;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic issue, resp, err_st, done;
  assign advance = state_q == IDLE && (if_req || dm_req);
  mem_arb_rr u_rr (
    .clock  (clock),
    .reset  (reset),
    .req    ({dm_req, if_req}),
    .advance(advance),
    .grant  (grant)
  );
  assign req_addr = grant == PORT_DM ? dm_addr : if_addr;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      port_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      port_q <= port_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  always_comb begin
    state_d = state_q == ISSUE ? RESP :
              state_q != IDLE ? IDLE :
              !advance ? IDLE :
              in_range(req_addr) ? ISSUE : ERR;
    port_d = advance ? grant : port_q;
    we_d = advance ? (grant == PORT_DM && dm_we) : we_q;
    addr_d = advance ? req_addr : addr_q;
    wdata_d = advance ? (grant == PORT_DM ? dm_wdata : '0) : wdata_q;
  end
  // mem_stage also drops with reset so a store caught mid-ISSUE never commits
  always_comb begin
    issue = state_q == ISSUE;
    resp = state_q == RESP;
    err_st = state_q == ERR;
    done = resp || err_st;
    mem_write = issue && we_q;
    mem_read = issue && !we_q;
    mem_address = issue ? addr_q : '0;
    mem_invalue = issue ? wdata_q : '0;
    mem_stage = issue && !reset ? MEM_STAGE : 3'd0;
    if_ack = done && port_q == PORT_IF;
    if_err = err_st && port_q == PORT_IF;
    if_rdata = resp && port_q == PORT_IF ? mem_outvalue : '0;
    dm_ack = done && port_q == PORT_DM;
    dm_err = err_st && port_q == PORT_DM;
    dm_rdata = resp && port_q == PORT_DM && !we_q ? mem_outvalue : '0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests of mem_arbiter against a preloaded stage-gated memory model
module tb_mem_arbiter;
  logic clock = 0, reset = 1;
  logic if_req = 0, dm_req = 0, dm_we = 0;
  logic [7:0] if_addr = 0, dm_addr = 0;
  logic [31:0] dm_wdata = 0;
  logic if_ack, if_err, dm_ack, dm_err, mem_write, mem_read;
  logic [31:0] if_rdata, dm_rdata, mem_invalue, mem_outvalue;
  logic [7:0] mem_address;
  logic [2:0] mem_stage;
  logic [31:0] mem_model [128];
  logic [31:0] exp_mem [128];
  int errors = 0, checks = 0, stage_cnt = 0;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
    .mem_invalue(mem_invalue), .mem_stage(mem_stage), .mem_outvalue(mem_outvalue)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_val(input int i);
    return 32'hA5A5_0000 ^ (i * 32'h0103_0507);
  endfunction

  always @(posedge clock) begin
    if (mem_stage != 0) stage_cnt <= stage_cnt + 1;
    if (mem_stage == 3'd3) begin
      if (mem_write) mem_model[mem_address[6:0]] <= mem_invalue;
      if (mem_read) mem_outvalue <= mem_model[mem_address[6:0]];
    end
  end

  task automatic dm_access(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                           output int cyc, output logic [31:0] rd, output logic er);
    @(negedge clock);
    dm_req = 1; dm_we = we; dm_addr = addr; dm_wdata = wd;
    cyc = -1; rd = '0; er = 0;
    for (int i = 1; i <= 10 && cyc < 0; i++) begin
      @(negedge clock);
      if (dm_ack) begin cyc = i; rd = dm_rdata; er = dm_err; end
    end
    dm_req = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    checks++;
    if ({if_ack, if_err, dm_ack, dm_err, mem_write, mem_read} !== 6'b0 || mem_stage !== 0 ||
        mem_address !== 0 || mem_invalue !== 0 || if_rdata !== 0 || dm_rdata !== 0) begin
      errors++; $display("FAIL reset_outputs: got acks/err/wr/rd=%b stage=%0d addr=%0h, want all 0",
        {if_ack, if_err, dm_ack, dm_err, mem_write, mem_read}, mem_stage, mem_address);
    end
    reset = 0;
  endtask

  task automatic test_fetch;
    @(negedge clock);
    if_req = 1; if_addr = 8'd5;
    @(negedge clock);
    checks++;
    if (mem_stage !== 3'd3 || mem_read !== 1 || mem_write !== 0 || mem_address !== 8'd5 || if_ack !== 0) begin
      errors++; $display("FAIL fetch_issue: stage=%0d rd=%b wr=%b addr=%0d ack=%b, want 3 1 0 5 0",
        mem_stage, mem_read, mem_write, mem_address, if_ack);
    end
    @(negedge clock);
    checks++;
    if (if_ack !== 1 || if_err !== 0 || if_rdata !== init_val(5) || dm_ack !== 0) begin
      errors++; $display("FAIL fetch_resp: ack=%b err=%b rdata=%h dm_ack=%b, want 1 0 %h 0",
        if_ack, if_err, if_rdata, dm_ack, init_val(5));
    end
    if_req = 0;
    @(negedge clock);
    checks++;
    if (if_ack !== 0 || if_rdata !== 0 || mem_stage !== 0) begin
      errors++; $display("FAIL fetch_after: ack=%b rdata=%h stage=%0d, want 0 0 0", if_ack, if_rdata, mem_stage);
    end
  endtask

  task automatic test_store_load;
    int cyc; logic [31:0] rd; logic er;
    dm_access(1, 8'd10, 32'hDEADBEEF, cyc, rd, er);
    exp_mem[10] = 32'hDEADBEEF;
    checks++;
    if (cyc !== 2 || rd !== 0 || er !== 0) begin
      errors++; $display("FAIL store10: cyc=%0d rdata=%h err=%b, want 2 0 0", cyc, rd, er);
    end
    dm_access(0, 8'd10, 32'h0, cyc, rd, er);
    checks++;
    if (cyc !== 2 || rd !== 32'hDEADBEEF || er !== 0) begin
      errors++; $display("FAIL load10: cyc=%0d rdata=%h err=%b, want 2 deadbeef 0", cyc, rd, er);
    end
    dm_access(1, 8'd127, 32'h0BAD_F00D, cyc, rd, er);
    exp_mem[127] = 32'h0BAD_F00D;
    dm_access(0, 8'd127, 32'h0, cyc, rd, er);
    checks++;
    if (cyc !== 2 || rd !== 32'h0BAD_F00D || er !== 0) begin
      errors++; $display("FAIL load127: cyc=%0d rdata=%h err=%b, want 2 0badf00d 0", cyc, rd, er);
    end
  endtask

  task automatic test_out_of_range;
    int cyc, s0; logic [31:0] rd; logic er;
    s0 = stage_cnt;
    dm_access(1, 8'd200, 32'h1234_5678, cyc, rd, er);
    checks++;
    if (cyc !== 1 || er !== 1 || rd !== 0) begin
      errors++; $display("FAIL oor200: cyc=%0d err=%b rdata=%h, want 1 1 0", cyc, er, rd);
    end
    dm_access(0, 8'd128, 32'h0, cyc, rd, er);
    checks++;
    if (cyc !== 1 || er !== 1 || rd !== 0) begin
      errors++; $display("FAIL oor128: cyc=%0d err=%b rdata=%h, want 1 1 0", cyc, er, rd);
    end
    checks++;
    if (stage_cnt !== s0) begin
      errors++; $display("FAIL oor_stage: stage active %0d cycles, want 0", stage_cnt - s0);
    end
    @(negedge clock);
    if_req = 1; if_addr = 8'd255;
    cyc = -1;
    for (int i = 1; i <= 10 && cyc < 0; i++) begin
      @(negedge clock);
      if (if_ack) begin cyc = i; rd = if_rdata; er = if_err; end
    end
    if_req = 0;
    checks++;
    if (cyc !== 1 || er !== 1 || rd !== 0) begin
      errors++; $display("FAIL if_oor255: cyc=%0d err=%b rdata=%h, want 1 1 0", cyc, er, rd);
    end
  endtask

  task automatic test_contention;
    logic exp_if, exp_dm;
    @(negedge clock);
    reset = 1; if_req = 1; if_addr = 8'd7; dm_req = 1; dm_we = 0; dm_addr = 8'd8;
    @(negedge clock);
    reset = 0;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clock);
      exp_if = (t == 2 || t == 8);
      exp_dm = (t == 5 || t == 11);
      checks++;
      if (if_ack !== exp_if || dm_ack !== exp_dm) begin
        errors++; $display("FAIL contend_t%0d: if_ack=%b dm_ack=%b, want %b %b", t, if_ack, dm_ack, exp_if, exp_dm);
      end
      if (t == 2) begin
        checks++;
        if (if_rdata !== init_val(7)) begin
          errors++; $display("FAIL contend_if_data: got %h want %h", if_rdata, init_val(7));
        end
      end
      if (t == 5) begin
        checks++;
        if (dm_rdata !== init_val(8)) begin
          errors++; $display("FAIL contend_dm_data: got %h want %h", dm_rdata, init_val(8));
        end
      end
    end
    if_req = 0; dm_req = 0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset_mid_op;
    @(negedge clock);
    dm_req = 1; dm_we = 1; dm_addr = 8'd20; dm_wdata = 32'h1357_9BDF;
    @(negedge clock);
    checks++;
    if (mem_stage !== 3'd3 || mem_write !== 1 || mem_address !== 8'd20) begin
      errors++; $display("FAIL midrst_issue: stage=%0d wr=%b addr=%0d, want 3 1 20", mem_stage, mem_write, mem_address);
    end
    reset = 1;
    #1;
    checks++;
    if (mem_stage !== 0) begin
      errors++; $display("FAIL midrst_stage: got %0d want 0", mem_stage);
    end
    @(negedge clock);
    checks++;
    if ({if_ack, if_err, dm_ack, dm_err, mem_write, mem_read} !== 6'b0 || mem_stage !== 0 ||
        mem_address !== 0 || mem_invalue !== 0 || dm_rdata !== 0) begin
      errors++; $display("FAIL midrst_outputs: acks/err/wr/rd=%b stage=%0d, want all 0",
        {if_ack, if_err, dm_ack, dm_err, mem_write, mem_read}, mem_stage);
    end
    dm_req = 0; reset = 0;
    checks++;
    if (mem_model[20] !== init_val(20)) begin
      errors++; $display("FAIL midrst_mem20: got %h want %h", mem_model[20], init_val(20));
    end
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (dm_ack !== 0) begin
        errors++; $display("FAIL midrst_noack: dm_ack=%b want 0", dm_ack);
      end
    end
  endtask

  task automatic test_early_drop;
    @(negedge clock);
    dm_req = 1; dm_we = 0; dm_addr = 8'd3;
    @(negedge clock);
    dm_req = 0;
    @(negedge clock);
    checks++;
    if (dm_ack !== 1 || dm_rdata !== init_val(3) || dm_err !== 0) begin
      errors++; $display("FAIL drop_resp: ack=%b rdata=%h err=%b, want 1 %h 0", dm_ack, dm_rdata, dm_err, init_val(3));
    end
    @(negedge clock);
    checks++;
    if (dm_ack !== 0 || mem_stage !== 0 || mem_read !== 0) begin
      errors++; $display("FAIL drop_idle: ack=%b stage=%0d rd=%b, want 0 0 0", dm_ack, mem_stage, mem_read);
    end
  endtask

  task automatic test_back_to_back;
    int cyc; logic [31:0] rd; logic er;
    dm_access(1, 8'd0, 32'hCAFE_0001, cyc, rd, er);
    exp_mem[0] = 32'hCAFE_0001;
    dm_access(0, 8'd0, 32'h0, cyc, rd, er);
    checks++;
    if (cyc !== 2 || rd !== 32'hCAFE_0001) begin
      errors++; $display("FAIL b2b_load0: cyc=%0d rdata=%h, want 2 cafe0001", cyc, rd);
    end
  endtask

  task automatic test_memory_image;
    int diffs = 0;
    for (int i = 0; i < 128; i++) if (mem_model[i] !== exp_mem[i]) diffs++;
    checks++;
    if (diffs != 0) begin
      errors++; $display("FAIL mem_image: %0d words differ, want 0", diffs);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem_model[i] = init_val(i);
      exp_mem[i] = init_val(i);
    end
    test_reset;
    test_fetch;
    test_store_load;
    test_out_of_range;
    test_contention;
    test_reset_mid_op;
    test_early_drop;
    test_back_to_back;
    test_memory_image;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
